// File: rtl/nonrestoring_divider_seq.sv
// Sequential unsigned divider using the non-restoring algorithm, one quotient bit per clock.
// A start/done handshake drives it; divide-by-zero returns all-ones quotient and the dividend as remainder.
module nonrestoring_divider_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] ZERO = 2'd3;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_reg;
  logic [WIDTH:0]   r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH:0] d_ext;
  logic [WIDTH:0] shift_r;
  logic [WIDTH:0] step_r_next;
  logic [WIDTH:0] fix_r_next;

  // Partial remainder can transiently exceed the signed range after the shift;
  // the add/sub result always lands back in [-D, D), so modular arithmetic is exact.
  always_comb begin
    d_ext       = {1'b0, d_reg};
    shift_r     = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    step_r_next = r_reg[WIDTH] ? (shift_r + d_ext) : (shift_r - d_ext);
    fix_r_next  = r_reg[WIDTH] ? (r_reg + d_ext) : r_reg;
  end

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      cnt_reg     <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            d_reg       <= divisor;
            q_reg       <= dividend;
            r_reg       <= '0;
            cnt_reg     <= CNT_LAST;
            div_by_zero <= 1'b0;
            state_reg   <= (divisor == '0) ? ZERO : RUN;
          end
        end
        RUN: begin
          r_reg <= step_r_next;
          q_reg <= {q_reg[WIDTH-2:0], ~step_r_next[WIDTH]};
          if (cnt_reg == '0) state_reg <= FIX;
          else               cnt_reg   <= cnt_reg - CW'(1);
        end
        FIX: begin
          r_reg     <= fix_r_next;
          quotient  <= q_reg;
          remainder <= fix_r_next[WIDTH-1:0];
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        ZERO: begin
          // q_reg still holds the untouched dividend here
          quotient    <= '1;
          remainder   <= q_reg;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider_seq.sv
// Randomised and directed bench for nonrestoring_divider_seq with a queue scoreboard
// fed by a plain-arithmetic reference model.
module tb_nonrestoring_divider_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t sb[$];

  nonrestoring_divider_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected result
  always @(negedge clk) begin
    if (!rst && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: q=%h r=%h dz=%b, required no done", quotient, remainder, div_by_zero);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
          errors++;
          $display("FAIL result %h/%h: got q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
                   e.a, e.b, quotient, remainder, div_by_zero, e.q, e.r, e.dz);
        end else begin
          $display("ok %h/%h -> q=%h r=%h dz=%b", e.a, e.b, quotient, remainder, div_by_zero);
        end
      end
    end
  end

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Counts edges from the accepting edge (edge 1) until done is visible.
  task automatic wait_done(output int edges);
    edges = 1;
    while (1) begin
      @(posedge clk); #1;
      edges++;
      if (done) break;
      if (edges > 200) begin
        errors++;
        $display("FAIL timeout: no done after %0d edges, required done", edges);
        break;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin @(posedge clk); #1; n++; end
    if (busy) begin
      errors++;
      $display("FAIL idle_timeout: busy still 1, required 0");
    end
  endtask

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int edges;
    wait_idle();
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    sb.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom;
    wait_done(edges);
    check("latency", edges, (b == 0) ? 2 : W + 2);
  endtask

  initial begin
    int edges, busy_cycles;
    logic [W-1:0] a, b;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", div_by_zero, 0);
    @(negedge clk); rst = 1'b0;

    // 100/7 with busy-length measurement
    @(negedge clk);
    start = 1'b1; dividend = 100; divisor = 7;
    sb.push_back(model(100, 7));
    @(posedge clk); #1; start = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    check("busy_cycles", busy_cycles, W + 1);

    do_div(32'hFFFFFFFF, 1);
    do_div(32'hFFFFFFFF, 32'hFFFFFFFF);
    do_div(3, 10);
    do_div(32'h80000000, 32'h00010000);
    do_div(5, 0);
    do_div(9, 3);
    check("dz_cleared", div_by_zero, 0);

    // start re-pulsed mid-run with other operands is ignored
    @(negedge clk);
    start = 1'b1; dividend = 100; divisor = 7;
    sb.push_back(model(100, 7));
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); start = 1'b1; dividend = 50; divisor = 5;
    @(negedge clk); start = 1'b0;
    wait_idle();

    // start held through done: back-to-back accept on the done cycle
    @(negedge clk);
    start = 1'b1; dividend = 1234567; divisor = 89;
    sb.push_back(model(1234567, 89));
    sb.push_back(model(1234567, 89));
    @(posedge clk); #1;
    wait_done(edges);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", busy, 1);
    wait_done(edges);
    check("b2b_latency", edges, W + 2);

    // asynchronous reset mid-RUN
    @(negedge clk);
    start = 1'b1; dividend = 100; divisor = 7;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", quotient, 0);
    check("arst_r", remainder, 0);
    check("arst_dz", div_by_zero, 0);
    @(negedge clk); rst = 1'b0;
    edges = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) edges++;
    end
    check("no_done_after_rst", edges, 0);
    do_div(1000, 33);

    // randomised operands, including zero and small divisors
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 0;
        1: b = $urandom_range(1, 16);
        2: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      do_div(a, b);
    end

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end
endmodule
